// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller.
// Contents: command opcodes, FSM state encoding, status byte bit positions,
// the framebuffer FIFO entry layout and a helper that assembles the status byte.
package spi_ctrl_pkg;

    // Command opcodes carried in byte 0 of every message
    localparam logic [7:0] OP_WRITE_REG = 8'h01;
    localparam logic [7:0] OP_READ_REG  = 8'h02;
    localparam logic [7:0] OP_FB_BURST  = 8'h03;
    localparam logic [7:0] OP_STATUS    = 8'h04;

    // Controller FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_WDATA   = 3'd3;
    localparam logic [2:0] ST_RDATA   = 3'd4;
    localparam logic [2:0] ST_FBDATA  = 3'd5;
    localparam logic [2:0] ST_DISCARD = 3'd6;

    // Status byte bit positions; bits 7..4 always read as zero
    localparam int STAT_ERR_BIT   = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_FULL_BIT  = 2;
    localparam int STAT_EMPTY_BIT = 3;

    // One framebuffer FIFO entry: start-of-burst marker plus pixel byte
    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fb_beat_t;

    // Assemble the status byte from the individual condition bits
    function automatic logic [7:0] make_status(input logic empty, input logic full,
                                               input logic ovf, input logic err);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_ERR_BIT]   = err;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, resetn          - clock, synchronous active-low reset
//   push, push_data      - write request and data; ignored when full unless a pop
//                          is accepted in the same cycle
//   pop                  - read request; ignored when empty
//   pop_data             - current head entry (valid while !empty)
//   empty, full          - occupancy flags
// DEPTH must be a power of two, at least 2, so the pointers wrap by overflow.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Occupancy flags and accepted-operation qualifiers
    always_comb begin
        empty_s   = (count_r == '0);
        full_s    = (count_r == (AW+1)'(DEPTH));
        pop_ok_s  = pop && !empty_s;
        // A full FIFO still takes a push when the head leaves in the same cycle
        push_ok_s = push && (!full_s || pop_ok_s);
    end

    // Storage, pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign empty    = empty_s;
    assign full     = full_s;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes byte-oriented SPI messages into register
// writes/reads, framebuffer bursts and status reads.
// Ports:
//   clk, resetn             - clock, synchronous active-low reset
//   rx_byte, received       - byte from the SPI slave and its completion pulse
//   start_message           - chip-select asserted pulse
//   end_message             - chip-select released pulse
//   tx_byte                 - byte to shift out on MISO for the next transfer
//   cfg_regs                - flattened register file, reg i at [8i+7:8i]
//   reg_wr, reg_wr_addr     - pulse and address of each register write
//   fb_data, fb_sof,
//   fb_valid, fb_ready      - framebuffer byte stream (valid/ready handshake)
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int NREG       = 8,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_byte,
    input  logic              received,
    input  logic              start_message,
    input  logic              end_message,
    output logic [7:0]        tx_byte,
    output logic [8*NREG-1:0] cfg_regs,
    output logic              reg_wr,
    output logic [AW-1:0]     reg_wr_addr,
    output logic [7:0]        fb_data,
    output logic              fb_sof,
    output logic              fb_valid,
    input  logic              fb_ready
);

    logic [2:0]        state_r;
    logic [AW-1:0]     ptr_r;
    logic              is_read_r;
    logic              sof_pending_r;
    logic [7:0]        tx_byte_r;
    logic [8*NREG-1:0] cfg_regs_r;
    logic              reg_wr_r;
    logic [AW-1:0]     reg_wr_addr_r;
    logic              ovf_r;
    logic              err_r;

    logic              byte_ok_s;
    logic [AW-1:0]     rx_idx_s;
    logic [AW-1:0]     ptr_inc_s;
    logic              status_hit_s;
    logic              illegal_hit_s;
    logic              push_s;
    logic              pop_s;
    logic [7:0]        status_s;
    fb_beat_t          push_beat_s;
    fb_beat_t          head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;

    // Byte qualification and per-cycle decode helpers
    always_comb begin
        // Framing pulses take priority over a byte completing in the same cycle
        byte_ok_s        = received && !start_message && !end_message;
        rx_idx_s         = rx_byte[AW-1:0];
        ptr_inc_s        = ptr_r + AW'(1'b1);
        status_hit_s     = byte_ok_s && (state_r == ST_CMD) && (rx_byte == OP_STATUS);
        illegal_hit_s    = byte_ok_s && (state_r == ST_CMD) &&
                           !(rx_byte inside {OP_WRITE_REG, OP_READ_REG, OP_FB_BURST, OP_STATUS});
        push_s           = byte_ok_s && (state_r == ST_FBDATA);
        pop_s            = !fifo_empty_s && fb_ready;
        push_beat_s.sof  = sof_pending_r;
        push_beat_s.data = rx_byte;
        status_s         = make_status(fifo_empty_s, fifo_full_s, ovf_r, err_r);
    end

    // Message FSM, register file, pointer and MISO byte
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            is_read_r     <= 1'b0;
            sof_pending_r <= 1'b0;
            tx_byte_r     <= 8'h00;
            cfg_regs_r    <= '0;
            reg_wr_r      <= 1'b0;
            reg_wr_addr_r <= '0;
        end else begin
            reg_wr_r <= 1'b0;
            if (start_message) begin
                state_r       <= ST_CMD;
                sof_pending_r <= 1'b1;
                tx_byte_r     <= 8'h00;
            end else if (end_message) begin
                state_r   <= ST_IDLE;
                tx_byte_r <= 8'h00;
            end else if (received) begin
                case (state_r)
                    ST_CMD: begin
                        case (rx_byte)
                            OP_WRITE_REG: begin
                                is_read_r <= 1'b0;
                                state_r   <= ST_ADDR;
                            end
                            OP_READ_REG: begin
                                is_read_r <= 1'b1;
                                state_r   <= ST_ADDR;
                            end
                            OP_FB_BURST: state_r <= ST_FBDATA;
                            OP_STATUS: begin
                                state_r   <= ST_DISCARD;
                                tx_byte_r <= status_s;
                            end
                            default: state_r <= ST_DISCARD;
                        endcase
                    end
                    ST_ADDR: begin
                        ptr_r <= rx_idx_s;
                        if (is_read_r) begin
                            state_r   <= ST_RDATA;
                            tx_byte_r <= cfg_regs_r[{rx_idx_s, 3'b000} +: 8];
                        end else begin
                            state_r <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        cfg_regs_r[{ptr_r, 3'b000} +: 8] <= rx_byte;
                        reg_wr_r      <= 1'b1;
                        reg_wr_addr_r <= ptr_r;
                        ptr_r         <= ptr_inc_s;
                    end
                    ST_RDATA: begin
                        // Preload the next register so it is ready for the next transfer
                        ptr_r     <= ptr_inc_s;
                        tx_byte_r <= cfg_regs_r[{ptr_inc_s, 3'b000} +: 8];
                    end
                    ST_FBDATA: sof_pending_r <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Sticky overflow and error flags; a set in the clearing cycle wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (status_hit_s) begin
                ovf_r <= 1'b0;
                err_r <= 1'b0;
            end
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
            if (illegal_hit_s) begin
                err_r <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fb_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fb_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (push_beat_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign tx_byte     = tx_byte_r;
    assign cfg_regs    = cfg_regs_r;
    assign reg_wr      = reg_wr_r;
    assign reg_wr_addr = reg_wr_addr_r;
    assign fb_data     = head_s.data;
    assign fb_sof      = head_s.sof;
    assign fb_valid    = !fifo_empty_s;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic compared with a message-level model.
module tb_spi_cmd_ctrl;

    localparam int NREG  = 8;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              received = 1'b0;
    logic              start_message = 1'b0;
    logic              end_message = 1'b0;
    logic              fb_ready = 1'b0;
    logic [7:0]        tx_byte;
    logic [8*NREG-1:0] cfg_regs;
    logic              reg_wr;
    logic [2:0]        reg_wr_addr;
    logic [7:0]        fb_data;
    logic              fb_sof;
    logic              fb_valid;

    int tests = 0;
    int fails = 0;

    spi_cmd_ctrl #(.NREG(NREG), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_byte       (rx_byte),
        .received      (received),
        .start_message (start_message),
        .end_message   (end_message),
        .tx_byte       (tx_byte),
        .cfg_regs      (cfg_regs),
        .reg_wr        (reg_wr),
        .reg_wr_addr   (reg_wr_addr),
        .fb_data       (fb_data),
        .fb_sof        (fb_sof),
        .fb_valid      (fb_valid),
        .fb_ready      (fb_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, then return 1 time unit after the rising edge
    task automatic drive(input logic rst, input logic st, input logic en, input logic rv,
                         input logic [7:0] b, input logic rdy);
        resetn = rst; start_message = st; end_message = en;
        received = rv; rx_byte = b; fb_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       st, en, rv;
        logic [7:0] b;
        logic       rdy;
        logic [7:0] tx;
        logic       wr;
        logic [2:0] wa;
        logic       fv;
        logic [7:0] fd;
        logic       fs;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic st, input logic en, input logic rv, input logic [7:0] b,
                     input logic rdy, input logic [7:0] tx, input logic wr, input logic [2:0] wa,
                     input logic fv, input logic [7:0] fd, input logic fs);
        vec_t r;
        r.st = st; r.en = en; r.rv = rv; r.b = b; r.rdy = rdy;
        r.tx = tx; r.wr = wr; r.wa = wa; r.fv = fv; r.fd = fd; r.fs = fs;
        vecs.push_back(r);
    endtask

    // ---------------- reference model (message level) ----------------
    typedef struct { logic [7:0] data; logic sof; } beat_t;
    logic [7:0] m_regs [NREG];
    beat_t      m_q[$];
    bit         m_in_msg, m_ovf, m_err, m_wr;
    int         m_idx, m_addr, m_wa;
    logic [7:0] m_cmd, m_tx;

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_q.delete();
        m_in_msg = 0; m_ovf = 0; m_err = 0; m_wr = 0;
        m_idx = 0; m_addr = 0; m_wa = 0; m_cmd = 8'h00; m_tx = 8'h00;
    endtask

    // Predict outputs after the coming edge from the current state and inputs
    task automatic m_step(input bit rst, input bit st, input bit en, input bit rv,
                          input logic [7:0] b, input bit rdy);
        bit    popping, pushing;
        beat_t nb;
        if (!rst) begin
            m_reset();
            return;
        end
        m_wr = 0;
        pushing = 0;
        popping = (m_q.size() > 0) && rdy;
        if (st) begin
            m_in_msg = 1; m_idx = 0; m_tx = 8'h00;
        end else if (en) begin
            m_in_msg = 0; m_tx = 8'h00;
        end else if (rv && m_in_msg) begin
            if (m_idx == 0) begin
                m_cmd = b;
                if (b == 8'h04) begin
                    m_tx = {4'h0, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_err};
                    m_ovf = 0; m_err = 0;
                end else if (b < 8'h01 || b > 8'h04) begin
                    m_err = 1;
                end
            end else begin
                case (m_cmd)
                    8'h01: begin
                        if (m_idx == 1) m_addr = b % NREG;
                        else begin
                            m_wa = (m_addr + m_idx - 2) % NREG;
                            m_regs[m_wa] = b; m_wr = 1;
                        end
                    end
                    8'h02: begin
                        if (m_idx == 1) begin
                            m_addr = b % NREG; m_tx = m_regs[m_addr];
                        end else m_tx = m_regs[(m_addr + m_idx - 1) % NREG];
                    end
                    8'h03: begin
                        if (m_q.size() < DEPTH || popping) begin
                            pushing = 1; nb.data = b; nb.sof = (m_idx == 1);
                        end else m_ovf = 1;
                    end
                    default: ;
                endcase
            end
            m_idx++;
        end
        if (popping) void'(m_q.pop_front());
        if (pushing) m_q.push_back(nb);
    endtask

    function automatic logic [63:0] m_packed();
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < NREG; i++) p[8*i +: 8] = m_regs[i];
        return p;
    endfunction

    task automatic m_compare();
        chk("rnd_tx", tx_byte, m_tx);
        chk("rnd_reg_wr", reg_wr, m_wr);
        if (m_wr) chk("rnd_wr_addr", reg_wr_addr, m_wa[2:0]);
        chk("rnd_cfg", cfg_regs, m_packed());
        chk("rnd_fb_valid", fb_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("rnd_fb_data", fb_data, m_q[0].data);
            chk("rnd_fb_sof", fb_sof, m_q[0].sof);
        end
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_cfg", cfg_regs, 64'h0);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_fb_valid", fb_valid, 1'b0);
        chk("rst_fb_sof", fb_sof, 1'b0);
        chk("rst_fb_data", fb_data, 8'h00);

        //  st en rv byte  rdy  tx    wr wa  fv fd    fs
        // WRITE_REG 01 06 AA BB CC
        v(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h01, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h06, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'hAA, 1, 8'h00, 1, 6, 0, 8'h00, 0);
        v(0, 0, 1, 8'hBB, 1, 8'h00, 1, 7, 0, 8'h00, 0);
        v(0, 0, 1, 8'hCC, 1, 8'h00, 1, 0, 0, 8'h00, 0);
        v(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        // READ_REG 02 07 00 00 00
        v(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h02, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h07, 1, 8'hBB, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h00, 1, 8'hCC, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        // FB_BURST 03 11 22 33, sink always ready
        v(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h03, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h11, 1, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h22, 1, 8'h00, 0, 0, 1, 8'h22, 0);
        v(0, 0, 1, 8'h33, 1, 8'h00, 0, 0, 1, 8'h33, 0);
        v(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        // FB_BURST 03 11 22 33, sink stalled: 33 dropped
        v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h03, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h11, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h22, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h33, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        // STATUS 04 00 -> 06, then again -> 04
        v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h04, 0, 8'h06, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h00, 0, 8'h06, 0, 0, 1, 8'h11, 1);
        v(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        v(0, 0, 1, 8'h04, 0, 8'h04, 0, 0, 1, 8'h11, 1);
        v(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h11, 1);
        // drain the two held beats
        v(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 8'h22, 0);
        v(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        // illegal 7F then 01 00 55 in the same message
        v(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h7F, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h01, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h55, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        // status shows err=1, FIFO empty
        v(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        v(0, 0, 1, 8'h04, 1, 8'h09, 0, 0, 0, 8'h00, 0);
        v(0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].st, vecs[i].en, vecs[i].rv, vecs[i].b, vecs[i].rdy);
            chk($sformatf("vec%0d_tx", i), tx_byte, vecs[i].tx);
            chk($sformatf("vec%0d_reg_wr", i), reg_wr, vecs[i].wr);
            if (vecs[i].wr) chk($sformatf("vec%0d_wr_addr", i), reg_wr_addr, vecs[i].wa);
            chk($sformatf("vec%0d_fb_valid", i), fb_valid, vecs[i].fv);
            if (vecs[i].fv) begin
                chk($sformatf("vec%0d_fb_data", i), fb_data, vecs[i].fd);
                chk($sformatf("vec%0d_fb_sof", i), fb_sof, vecs[i].fs);
            end
            if (i == 6) chk("vec_cfg_after_write", cfg_regs, 64'hBBAA0000000000CC);
        end
        chk("cfg_after_illegal", cfg_regs, 64'hBBAA0000000000CC);

        // Reset in the middle of a WDATA phase with a held FIFO beat
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("pre_rst_fb_valid", fb_valid, 1'b1);
        chk("pre_rst_reg3", cfg_regs[31:24], 8'h77);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h88, 1'b0);
        chk("mid_rst_tx", tx_byte, 8'h00);
        chk("mid_rst_cfg", cfg_regs, 64'h0);
        chk("mid_rst_reg_wr", reg_wr, 1'b0);
        chk("mid_rst_fb_valid", fb_valid, 1'b0);
        chk("mid_rst_fb_sof", fb_sof, 1'b0);
        chk("mid_rst_fb_data", fb_data, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        chk("post_rst_ignored_wr", reg_wr, 1'b0);
        chk("post_rst_ignored_cfg", cfg_regs, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        chk("post_rst_wr", reg_wr, 1'b1);
        chk("post_rst_wr_addr", reg_wr_addr, 3'd2);
        chk("post_rst_cfg", cfg_regs, 64'h0000000000990000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // start_message with a byte in the same cycle: the byte is not the command
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        chk("start_wins_status", tx_byte, 8'h08);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic against the model
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            bit         rst, st, en, rv, rdy;
            logic [7:0] b;
            rst = ($urandom_range(0, 399) != 0);
            st  = ($urandom_range(0, 15) == 0);
            en  = !st && ($urandom_range(0, 19) == 0);
            rv  = !en && ($urandom_range(0, 1) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            b   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            m_step(rst, st, en, rv, b, rdy);
            drive(rst, st, en, rv, b, rdy);
            m_compare();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
